// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two requester ports share one single-port data memory.
// Each transaction takes three cycles (IDLE sample, ACCESS, RESP); ties are
// broken round-robin so neither port can be starved.
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          owner;      // port that owns the current transaction
    logic          last_gnt;   // port granted most recently (round-robin pointer)
    logic          txn_we;
    logic [AW-1:0] txn_addr;
    logic [DW-1:0] txn_wdata;
    logic          start;
    logic          pick;

    // Winner selection: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        start = (state == IDLE) && (req0 || req1);
        if (req0 && req1) begin
            pick = ~last_gnt;
        end else begin
            pick = req1;
        end
    end

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch owner and payload at grant; later changes on the ports are ignored.
    // Reset puts the pointer back on port 1 so port 0 wins the next tie, which
    // also discards any pointer move made by a transaction that reset aborts.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= 1'b0;
            last_gnt  <= 1'b1;
            txn_we    <= 1'b0;
            txn_addr  <= '0;
            txn_wdata <= '0;
        end else if (start) begin
            owner     <= pick;
            last_gnt  <= pick;
            txn_we    <= pick ? we1 : we0;
            txn_addr  <= pick ? addr1 : addr0;
            txn_wdata <= pick ? wdata1 : wdata0;
        end
    end

    // Capture load data into the owner's register in RESP, where mem_rdata is valid.
    // The new value is visible from the cycle after the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state == RESP && !txn_we) begin
            if (owner) begin
                rdata1 <= mem_rdata;
            end else begin
                rdata0 <= mem_rdata;
            end
        end
    end

    // Next-state and output decode; the memory bus is driven only during ACCESS.
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                gnt0       = ~owner;
                gnt1       = owner;
                mem_en     = 1'b1;
                mem_we     = txn_we;
                mem_addr   = txn_addr;
                mem_wdata  = txn_wdata;
                state_next = RESP;
            end
            RESP: begin
                gnt0       = ~owner;
                gnt1       = owner;
                done0      = ~owner;
                done1      = owner;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus random two-port traffic,
// checked by a scoreboard against a transaction-level memory model.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, done0, done1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // scoreboard state
    txn_t          q0[$];
    txn_t          q1[$];
    logic [DW-1:0] ref_mem [256];
    logic          mon_on = 1'b0;
    logic          p_req0 = 1'b0, p_req1 = 1'b0;
    logic          last_w = 1'b1;
    logic          prev_en_v = 1'b0, prev_en_w = 1'b0;
    logic          exp_w;
    logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;
    int            wait0 = 0, wait1 = 0;
    int            en_cnt = 0, we_cnt = 0, g1_cnt = 0, d1_cnt = 0;
    int            grant_log[$];
    int            done_cyc[$];
    txn_t          mon_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Initial memory contents, shared by the memory model and the reference.
    function automatic logic [DW-1:0] init_val(input int i);
        case (i)
            3:       return 16'h0004;
            32:      return 16'h1234;
            33:      return 16'h5678;
            default: return 16'((i * 16'h9E37) ^ 16'h5A5A);
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // Memory model: load data is valid the cycle after mem_en, junk otherwise.
    initial begin
        logic [DW-1:0] mem [256];
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_en && mem_we) begin
                mem[mem_addr] <= mem_wdata;
            end
            if (mem_en && !mem_we) begin
                mem_rdata <= mem[mem_addr];
            end else begin
                mem_rdata <= 16'($urandom);
            end
        end
    end

    // Retire a completed transaction of port p against the reference memory.
    task automatic finish_txn(input int p);
        txn_t t;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            check("done_without_request", 0, 1);
            return;
        end
        if (p == 0) t = q0.pop_front();
        else        t = q1.pop_front();
        if (t.we) begin
            ref_mem[t.addr] = t.wdata;
        end else if (p == 0) begin
            exp_rd0 = ref_mem[t.addr];
        end else begin
            exp_rd1 = ref_mem[t.addr];
        end
        if (p == 0) begin
            check("starve0", 32'(wait0 <= 2), 1);
            wait0 = 0;
            if (q1.size() > 0) wait1++;
        end else begin
            check("starve1", 32'(wait1 <= 2), 1);
            wait1 = 0;
            if (q0.size() > 0) wait0++;
        end
    endtask

    // Monitor: compares DUT outputs against the model on every falling edge.
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (reset) begin
                q0.delete();
                q1.delete();
                last_w    = 1'b1;
                exp_rd0   = '0;
                exp_rd1   = '0;
                prev_en_v = 1'b0;
                wait0     = 0;
                wait1     = 0;
            end else if (mon_on) begin
                check("gnt_onehot", 32'(gnt0 & gnt1), 0);
                check("rdata0", 32'(rdata0), 32'(exp_rd0));
                check("rdata1", 32'(rdata1), 32'(exp_rd1));
                check("busy", 32'(busy), 32'(mem_en | done0 | done1));
                check("gnt_active", 32'(gnt0 | gnt1), 32'(mem_en | done0 | done1));
                check("done0_timing", 32'(done0), 32'(prev_en_v && !prev_en_w));
                check("done1_timing", 32'(done1), 32'(prev_en_v && prev_en_w));
                if (gnt1) g1_cnt++;
                if (done0) begin
                    check("gnt0_with_done", 32'(gnt0), 1);
                    done_cyc.push_back(cyc);
                    finish_txn(0);
                end
                if (done1) begin
                    check("gnt1_with_done", 32'(gnt1), 1);
                    d1_cnt++;
                    done_cyc.push_back(cyc);
                    finish_txn(1);
                end
                prev_en_v = mem_en;
                if (mem_en) begin
                    en_cnt++;
                    if (mem_we) we_cnt++;
                    exp_w = (p_req0 && p_req1) ? ~last_w : p_req1;
                    check("arb_any_req", 32'(p_req0 | p_req1), 1);
                    check("arb_winner", 32'({gnt1, gnt0}), exp_w ? 32'd2 : 32'd1);
                    last_w    = exp_w;
                    prev_en_w = exp_w;
                    grant_log.push_back(int'(gnt1));
                    if ((exp_w && q1.size() == 0) || (!exp_w && q0.size() == 0)) begin
                        check("bus_without_txn", 0, 1);
                    end else begin
                        mon_t = exp_w ? q1[0] : q0[0];
                        check("bus_we", 32'(mem_we), 32'(mon_t.we));
                        check("bus_addr", 32'(mem_addr), 32'(mon_t.addr));
                        if (mon_t.we) check("bus_wdata", 32'(mem_wdata), 32'(mon_t.wdata));
                    end
                end else begin
                    check("bus_idle_zero", 32'({mem_we, mem_addr, mem_wdata}), 0);
                end
            end
            p_req0 = req0;
            p_req1 = req1;
        end
    end

    // Issue one transaction on port p and hold req until done. Called and
    // returns just after a rising edge; req is dropped on return.
    task automatic do_txn(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat);
        txn_t t;
        t = '{we: we, addr: a, wdata: d};
        if (p == 0) begin
            q0.push_back(t);
            we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
        end else begin
            q1.push_back(t);
            we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
        end
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((p == 0 && done0) || (p == 1 && done1)) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("txn_timeout", 0, 1);
        @(posedge clk); #1;
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    task automatic reset_dut();
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic random_port(input int p, input int n);
        int lat;
        for (int k = 0; k < n; k++) begin
            do_txn(p, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom), lat);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        int   lat, lat_a, lat_b, n, m, e0, w0, d10, g10;
        txn_t t;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_on = 1'b1;
        check("rst_ctrl", 32'({gnt0, gnt1, done0, done1, mem_en, mem_we, busy}), 0);
        check("rst_bus", 32'({mem_addr, mem_wdata}), 0);
        check("rst_rdata", 32'({rdata0, rdata1}), 0);

        // port 0 load of address 3
        g10 = g1_cnt;
        do_txn(0, 1'b0, 8'h03, 16'h0, lat);
        check("r035_latency", 32'(lat), 2);
        check("r035_rdata0", 32'(rdata0), 32'h0004);
        check("r035_no_gnt1", 32'(g1_cnt - g10), 0);

        // port 1 store, then read back through port 0
        e0 = en_cnt; w0 = we_cnt; d10 = d1_cnt;
        do_txn(1, 1'b1, 8'h10, 16'hBEEF, lat);
        check("r036_latency", 32'(lat), 2);
        check("r036_en_cycles", 32'(en_cnt - e0), 1);
        check("r036_we_cycles", 32'(we_cnt - w0), 1);
        check("r036_done1_count", 32'(d1_cnt - d10), 1);
        do_txn(0, 1'b0, 8'h10, 16'h0, lat);
        check("r036_readback", 32'(rdata0), 32'hBEEF);

        // both ports held for four transactions after reset
        reset_dut();
        n = grant_log.size();
        m = done_cyc.size();
        fork
            begin
                do_txn(0, 1'b0, 8'h01, 16'h0, lat_a);
                do_txn(0, 1'b1, 8'h02, 16'h1111, lat_a);
            end
            begin
                do_txn(1, 1'b0, 8'h03, 16'h0, lat_b);
                do_txn(1, 1'b1, 8'h04, 16'h2222, lat_b);
            end
        join
        if (grant_log.size() < n + 4 || done_cyc.size() < m + 4) begin
            check("r037_count", 0, 1);
        end else begin
            for (int i = 0; i < 4; i++) check("r037_order", 32'(grant_log[n + i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) check("r037_spacing", 32'(done_cyc[m + i] - done_cyc[m + i - 1]), 3);
        end

        // req0 dropped (and payload scrambled) right after being sampled
        t = '{we: 1'b0, addr: 8'h03, wdata: 16'h0};
        q0.push_back(t);
        we0 = 1'b0; addr0 = 8'h03; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; we0 = 1'b1; addr0 = 8'hAA; wdata0 = 16'hFFFF;
        @(negedge clk);
        check("r038_mem_en", 32'(mem_en), 1);
        check("r038_addr", 32'(mem_addr), 32'h03);
        @(negedge clk);
        check("r038_done0", 32'(done0), 1);
        @(posedge clk); #1;

        // reset during ACCESS of a port-1 load
        do_txn(1, 1'b0, 8'h20, 16'h0, lat);
        check("r039_pre_rdata1", 32'(rdata1), 32'h1234);
        t = '{we: 1'b0, addr: 8'h21, wdata: 16'h0};
        q1.push_back(t);
        we1 = 1'b0; addr1 = 8'h21; req1 = 1'b1;
        @(posedge clk); #1;
        check("r039_in_access", 32'(mem_en & gnt1), 1);
        reset = 1'b1; req1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("r039_state", 32'({busy, gnt0, gnt1, done1}), 0);
        check("r039_rdata1", 32'(rdata1), 0);
        @(negedge clk);
        check("r039_no_done1", 32'(done1), 0);
        @(posedge clk); #1;
        n = grant_log.size();
        fork
            do_txn(0, 1'b0, 8'h05, 16'h0, lat_a);
            do_txn(1, 1'b0, 8'h06, 16'h0, lat_b);
        join
        if (grant_log.size() < n + 1) check("r039_tie_count", 0, 1);
        else check("r039_tie_port0", 32'(grant_log[n]), 0);

        // random traffic on both ports
        fork
            random_port(0, 40);
            random_port(1, 40);
        join
        repeat (5) @(posedge clk);
        check("queues_drained", 32'(q0.size() + q1.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 8, data-memory address width.
REQ-002 Parameter DW, default 16, data-memory word width.
REQ-003 Clock is clk and reset is reset; one clock, reset synchronous and active-high.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req0, req1  in  1 each  access request from port 0 (core load/store) and port 1 (loader/debug).
REQ-007 we0, we1  in  1 each  1 = store, 0 = load, per port.
REQ-008 addr0, addr1  in  AW each  word address, per port.
REQ-009 wdata0, wdata1  in  DW each  store data, per port.
REQ-010 gnt0, gnt1  out  1 each  port owns the memory for the current transaction.
REQ-011 done0, done1  out  1 each  one-cycle completion pulse, per port.
REQ-012 rdata0, rdata1  out  DW each  registered load data, per port.
REQ-013 mem_en, mem_we  out  1 each  memory access strobe and write enable.
REQ-014 mem_addr  out  AW  memory address; mem_wdata  out  DW  memory write data.
REQ-015 mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 FSM states are IDLE, ACCESS and RESP, and no other state shall be reachable.
REQ-018 In IDLE with any req high, the block shall select a winner, latch its we/addr/wdata, and move to ACCESS next cycle.
REQ-019 In IDLE with no req, the block shall stay in IDLE with all outputs at idle values.
REQ-020 Winner selection: single requester wins; with both high, the port not granted last wins (round-robin pointer).
REQ-021 The pointer shall update only when a transaction is granted.
REQ-022 In ACCESS, mem_en shall be high for exactly one cycle with the latched mem_we/mem_addr/mem_wdata, then the FSM moves to RESP.
REQ-023 In RESP, for a load, the block shall capture mem_rdata into the winner's rdata register, pulse the winner's done for one cycle, and return to IDLE.
REQ-024 In RESP, for a store, the block shall pulse done and leave rdata unchanged.
REQ-025 gnt of the winner shall be high in ACCESS and RESP only, and gnt0 and gnt1 shall never both be high.
REQ-026 Latency: req sampled in cycle N gives mem_en in N+1 and done in N+2; the next grant is sampled in N+3, for a maximum of one transaction per 3 cycles.
REQ-027 Starvation bound: a continuously held req shall be granted within 2 transactions.
REQ-028 A transaction, once latched, shall complete even if req or its payload changes or drops; new payload is ignored until the next IDLE sample.
REQ-029 Requesters shall hold req until done; req still high in the cycle after done is a new request.
REQ-030 The rdata of the losing port and of store transactions shall hold their previous value.
REQ-031 mem_addr/mem_wdata/mem_we shall be 0 whenever mem_en is 0.

Reset
REQ-032 reset high at a clock edge shall force IDLE and set the pointer so that port 0 wins the next tie.
REQ-033 reset shall set gnt*, done*, mem_en, mem_we, mem_addr, mem_wdata, busy and rdata0/rdata1 to 0.
REQ-034 Reset asserted in ACCESS or RESP shall abort the transaction with no done pulse, and the aborted port shall not advance the pointer.

Verification
REQ-035 After reset, req0 load addr=0x03 with memory[3]=0x0004 -> mem_en in cycle N+1 with addr 0x03 and we=0, done0 in N+2, rdata0=0x0004, gnt1 never high.
REQ-036 req1 store addr=0x10 wdata=0xBEEF -> mem_en=1 and mem_we=1 for one cycle, done1 pulses once, and a later load of 0x10 via port 0 returns 0xBEEF.
REQ-037 req0 and req1 both held for 4 transactions from reset -> grant order 0,1,0,1, with done pulses at 3-cycle spacing.
REQ-038 req0 dropped in cycle N+1 after sampling -> transaction still completes and done0 pulses in N+2.
REQ-039 reset pulsed during ACCESS of a port-1 load -> no done1, rdata1=0, state IDLE; with both ports then requesting, port 0 wins.
REQ-040 Random req/we/addr traffic against a reference memory model -> all loads match, gnt one-hot-or-zero every cycle, and no port waits more than 2 transactions.
